// File: rtl/axis_mem_reader.sv
// AXI4-Stream frame source: reads a byte-length command's worth of words from a
// 1-cycle-latency synchronous RAM and emits them as a single AXIS frame.
module axis_mem_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 20,
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [USER_WIDTH-1:0] cmd_user,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  vld_q, vld_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;

    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_WIDTH-1:0]  rd_left_q, rd_left_d;
    logic [KEEP_WIDTH-1:0] last_keep_q, last_keep_d;
    logic [USER_WIDTH-1:0] user_q, user_d;
    logic                  vld_last_q, vld_last_d;
    logic [KEEP_WIDTH-1:0] vld_keep_q, vld_keep_d;

    logic [DATA_WIDTH-1:0] data_mem [2];
    logic [KEEP_WIDTH-1:0] keep_mem [2];
    logic                  last_mem [2];

    logic [LEN_WIDTH-1:0]  cmd_rem;
    logic [LEN_WIDTH-1:0]  cmd_beats;
    logic [KEEP_WIDTH-1:0] cmd_keep;
    logic                  push;
    logic                  pop;
    logic [2:0]            occ_after;
    logic                  rd_en;
    logic                  issue_last;

    assign cmd_rem   = LEN_WIDTH'(cmd_len % LEN_WIDTH'(KEEP_WIDTH));
    assign cmd_beats = LEN_WIDTH'(cmd_len / LEN_WIDTH'(KEEP_WIDTH)) + LEN_WIDTH'(cmd_rem != '0);

    always_comb begin
        cmd_keep = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            cmd_keep[i] = (cmd_rem == '0) || (LEN_WIDTH'(i) < cmd_rem);
        end
    end

    // Credit counts this cycle's pop, so a full-rate stream keeps one beat in
    // the FIFO and one on the RAM bus without ever overflowing two entries.
    assign push       = vld_q;
    assign pop        = m_axis_tvalid && m_axis_tready;
    assign occ_after  = {1'b0, count_q} + {2'b00, vld_q} - {2'b00, pop};
    assign rd_en      = (state_q == S_READ) && (occ_after < 3'd2);
    assign issue_last = rd_en && (rd_left_q == LEN_WIDTH'(1));

    always_comb begin
        // NOTE: every _d starts from its _q (or a pulse default) so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_left_d   = rd_left_q;
        last_keep_d = last_keep_q;
        user_d      = user_q;
        vld_d       = rd_en;
        vld_last_d  = issue_last;
        vld_keep_d  = issue_last ? last_keep_q : '1;
        wr_ptr_d    = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d    = pop ? ~rd_ptr_q : rd_ptr_q;
        count_d     = count_q + {1'b0, push} - {1'b0, pop};

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    rd_addr_d   = cmd_addr;
                    rd_left_d   = cmd_beats;
                    last_keep_d = cmd_keep;
                    user_d      = cmd_user;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = S_READ;
                        busy_d      = 1'b1;
                        cmd_ready_d = 1'b0;
                    end
                end
            end
            S_READ: begin
                if (rd_en) begin
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                    rd_left_d = rd_left_q - LEN_WIDTH'(1);
                    if (issue_last) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && m_axis_tlast) begin
                    state_d     = S_IDLE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vld_q       <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the pre-edge value of every other.
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            vld_q       <= vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // NOTE: payload registers and FIFO storage carry no reset; the control flops above already mark them invalid.
    always_ff @(posedge clk) begin
        rd_addr_q   <= rd_addr_d;
        rd_left_q   <= rd_left_d;
        last_keep_q <= last_keep_d;
        user_q      <= user_d;
        vld_last_q  <= vld_last_d;
        vld_keep_q  <= vld_keep_d;
        if (push) begin
            data_mem[wr_ptr_q] <= mem_rd_data;
            keep_mem[wr_ptr_q] <= vld_keep_q;
            last_mem[wr_ptr_q] <= vld_last_q;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign mem_rd_en     = rd_en;
    assign mem_rd_addr   = rd_addr_q;
    assign m_axis_tvalid = (count_q != 2'd0);
    assign m_axis_tdata  = data_mem[rd_ptr_q];
    assign m_axis_tkeep  = keep_mem[rd_ptr_q];
    assign m_axis_tlast  = last_mem[rd_ptr_q];
    assign m_axis_tuser  = user_q;

endmodule

// File: tb/tb_axis_mem_reader.sv
// Self-checking bench for axis_mem_reader: a beat-queue model built from each command
// is compared against the stream every valid cycle, plus literal checks per scenario.
module tb_axis_mem_reader;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int AW = 16;
    localparam int LW = 20;
    localparam int UW = 1;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [UW-1:0] cmd_user;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic [UW-1:0] m_axis_tuser;
    logic          busy;
    logic          done;

    axis_mem_reader #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .USER_WIDTH(UW)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_user(cmd_user),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    beat_t         exp_q[$];
    logic [AW-1:0] rd_log[$];
    int            n_pass = 0;
    int            n_total = 0;
    int            cyc = 0;
    int            done_due = -1;
    bit            frame_active = 0;
    bit            checking = 0;
    int            rdy_mode = 0;
    int            accept_cyc, first_valid_cyc, last_pop_cyc, beats_seen;
    bit            seen_first;
    logic [KW-1:0] last_keep_seen;
    logic [DW-1:0] first_data_seen;

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        return {16'hA5A5, a, 16'h0000, ~a};
    endfunction

    // RAM model: registered read, data valid the cycle after the strobe
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= ram_word(mem_rd_addr);
            rd_log.push_back(mem_rd_addr);
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ($urandom_range(0, 9) < 3);
            default: m_axis_tready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst && checking) begin
            check("busy", busy, frame_active);
            check("cmd_ready", cmd_ready, !frame_active);
            if (done || cyc == done_due) check("done", done, cyc == done_due);
            if (m_axis_tvalid) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1'b1, 1'b0);
                end else begin
                    check("beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, exp_q[0]);
                    if (!seen_first) begin
                        seen_first      = 1;
                        first_valid_cyc = cyc;
                        first_data_seen = m_axis_tdata;
                    end
                    if (m_axis_tready) begin
                        beats_seen++;
                        last_keep_seen = m_axis_tkeep;
                        if (exp_q[0].last) begin
                            frame_active = 0;
                            done_due     = cyc + 1;
                            last_pop_cyc = cyc;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] len,
                            input logic [UW-1:0] u, input bit hold);
        bit acc;
        int beats;
        acc       = 0;
        cmd_addr  = a;
        cmd_len   = len;
        cmd_user  = u;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3000 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready;
        end
        if (!acc) begin
            check("cmd_accept_timeout", 1'b0, 1'b1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
        accept_cyc = cyc;
        seen_first = 0;
        beats_seen = 0;
        beats      = (int'(len) + KW - 1) / KW;
        for (int i = 0; i < beats; i++) begin
            beat_t b;
            b.data = ram_word(a + AW'(i));
            b.keep = (i == beats - 1 && int'(len) % KW != 0) ? KW'((1 << (int'(len) % KW)) - 1) : '1;
            b.last = (i == beats - 1);
            b.user = u;
            exp_q.push_back(b);
        end
        if (beats == 0) done_due = cyc + 1;
        else frame_active = 1;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || frame_active || done_due >= cyc) && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        if (n >= max_cyc) check("idle_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_user  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_rd_en", mem_rd_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst      = 1'b0;
        checking = 1;
        @(posedge clk);
        #1;

        // 1: aligned 4-beat frame at full rate
        rdy_mode = 0;
        send_cmd(16'h0010, 20'd32, 1'b0, 0);
        wait_idle(200);
        check("t1_beats", beats_seen, 4);
        check("t1_first_data", first_data_seen, 64'hA5A5_0010_0000_FFEF);
        check("t1_last_keep", last_keep_seen, 8'hFF);
        check("t1_latency", first_valid_cyc - accept_cyc, 3);
        check("t1_no_bubbles", last_pop_cyc - first_valid_cyc, 3);

        // 2: partial last beat, then an empty frame
        send_cmd(16'h0040, 20'd13, 1'b1, 0);
        wait_idle(200);
        check("t2_beats", beats_seen, 2);
        check("t2_last_keep", last_keep_seen, 8'h1F);
        rd_log.delete();
        send_cmd(16'h0050, 20'd0, 1'b0, 0);
        wait_idle(50);
        check("t2_len0_beats", beats_seen, 0);
        check("t2_len0_reads", rd_log.size(), 0);

        // 3: 100 beats under a sparse tready
        rdy_mode = 1;
        send_cmd(16'h0200, 20'd800, 1'b1, 0);
        wait_idle(5000);
        check("t3_beats", beats_seen, 100);
        rdy_mode = 0;

        // 4: address wraps at the top of RAM
        @(posedge clk);
        #1;
        rd_log.delete();
        send_cmd(16'hFFFE, 20'd32, 1'b0, 0);
        wait_idle(200);
        check("t4_nreads", rd_log.size(), 4);
        check("t4_addr0", rd_log[0], 16'hFFFE);
        check("t4_addr1", rd_log[1], 16'hFFFF);
        check("t4_addr2", rd_log[2], 16'h0000);
        check("t4_addr3", rd_log[3], 16'h0001);

        // 5: reset mid-frame with the FIFO full
        rdy_mode = 2;
        send_cmd(16'h0100, 20'd800, 1'b0, 0);
        repeat (10) @(posedge clk);
        #1;
        check("t5_stalled_valid", m_axis_tvalid, 1'b1);
        #1;
        checking = 0;
        rst      = 1'b1;
        #1;
        check("t5_rst_cmd_ready", cmd_ready, 1'b1);
        check("t5_rst_tvalid", m_axis_tvalid, 1'b0);
        check("t5_rst_rd_en", mem_rd_en, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_done", done, 1'b0);
        exp_q.delete();
        frame_active = 0;
        done_due     = -1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        checking = 1;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send_cmd(16'h0020, 20'd24, 1'b1, 0);
        wait_idle(200);
        check("t5_beats", beats_seen, 3);
        check("t5_first_data", first_data_seen, 64'hA5A5_0020_0000_FFDF);

        // 6: back-to-back commands with cmd_valid held
        send_cmd(16'h0300, 20'd16, 1'b0, 1);
        send_cmd(16'h0310, 20'd16, 1'b1, 0);
        wait_idle(200);
        check("t6_beats", beats_seen, 2);
        check("t6_first_data", first_data_seen, 64'hA5A5_0310_0000_FCEF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
